wishbone_ifetch_master: RTL

- Wishbone classic-cycle read initiator that fetches 32-bit instruction words on behalf of the RISC-V core.
- It is the bus-master counterpart to the team's Wishbone ROM/RAM responders. It accepts one fetch request at a time from the core and drives cyc/stb/adr/sel.
- It returns the word with a one-cycle valid pulse and reports misaligned or timed-out fetches as errors.

---
 rtl/wishbone_ifetch_master.sv | 119 +++++++++++
 1 files changed

// File: rtl/wishbone_ifetch_master.sv
`default_nettype none
// ============================================================================
// Module   : wishbone_ifetch_master
// Purpose  : Wishbone classic-cycle read initiator fetching 32-bit words for
//            the core, with misalignment and bus-timeout error reporting.
// Revision : 1.0 - initial release
// ============================================================================
module wishbone_ifetch_master #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic [31:0]       pc_i,
    input  logic              flush_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [31:0]       instr_o,
    output logic              err_o,
    output logic              cyc_o,
    output logic              stb_o,
    output logic              we_o,
    output logic [3:0]        sel_o,
    output logic [ADDR_W-1:0] adr_o,
    input  logic [31:0]       dat_i,
    input  logic              ack_i
);

    localparam int               CNT_W      = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e             state_q;
    logic               cyc_q;
    logic [3:0]         sel_q;
    logic [ADDR_W-1:0]  adr_q;
    logic [31:0]        instr_q;
    logic               valid_q;
    logic               err_q;
    logic               discard_q;
    logic [CNT_W-1:0]   cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cyc_q     <= 1'b0;
            sel_q     <= 4'h0;
            adr_q     <= '0;
            instr_q   <= 32'h0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            discard_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_i) begin
                        if (pc_i[1:0] != 2'b00) begin
                            err_q <= 1'b1;
                        end else begin
                            adr_q     <= pc_i[ADDR_W+1:2];
                            sel_q     <= 4'hF;
                            cnt_q     <= '0;
                            discard_q <= 1'b0;
                            cyc_q     <= 1'b1;
                            state_q   <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    // A flush only marks the result stale; the bus cycle runs to its end.
                    if (flush_i) begin
                        discard_q <= 1'b1;
                    end
                    if (ack_i) begin
                        instr_q <= dat_i;
                        valid_q <= !(discard_q || flush_i);
                        cyc_q   <= 1'b0;
                        sel_q   <= 4'h0;
                        state_q <= S_IDLE;
                    end else if (cnt_q == C_CNT_LAST) begin
                        err_q   <= 1'b1;
                        cyc_q   <= 1'b0;
                        sel_q   <= 4'h0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    generate
        if (ADDR_W + 2 < 32) begin : g_pc_unused
            wire w_unused_pc = &{1'b0, pc_i[31:ADDR_W+2]};
        end
    endgenerate

    assign ready_o = (state_q == S_IDLE);
    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign err_o   = err_q;
    assign cyc_o   = cyc_q;
    assign stb_o   = cyc_q;
    assign we_o    = 1'b0;
    assign sel_o   = sel_q;
    assign adr_o   = adr_q;

endmodule
`default_nettype wire
